// File: rtl/view_matrix_pkg.sv
// Shared types and constants for the view-matrix sequencer and its
// double-buffered column bank.
package view_matrix_pkg;

    typedef logic [2:0][31:0] vec3_t;
    typedef logic [3:0][31:0] col_t;
    typedef col_t [3:0]       mat4_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_COLLECT,
        ST_PENDING
    } state_t;

    localparam logic [31:0] FP32_ONE = 32'h3F80_0000;

endpackage

// File: rtl/view_matrix_bank.sv
// Shadow/active double buffer: beats fill the shadow bank, a swap strobe
// copies it to the active bank, and only the active bank is readable.
module view_matrix_bank
    import view_matrix_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_idx,
    input  col_t       wr_col,
    input  logic       clear,
    input  logic       swap,
    input  logic [1:0] rd_idx,
    output col_t       rd_col
);

    mat4_t shadow;
    mat4_t active;

    // NOTE: both banks are reset on purpose: the read port must show zeros
    // after reset, so these cannot be left as uninitialised storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (clear) begin
                shadow <= '0;
            end else if (wr_en) begin
                shadow[wr_idx] <= wr_col;
            end
            if (swap) begin
                active <= shadow;
            end
        end
    end

    assign rd_col = active[rd_idx];

endmodule

// File: rtl/view_matrix_ctrl.sv
// Camera-update sequencer for matrix_gen: latches operands, issues a
// one-cycle request, collects four columns and commits them on a frame pulse.
module view_matrix_ctrl
    import view_matrix_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             cam_valid_in,
    output logic             cam_ready_out,
    input  logic [2:0][31:0] pos_in,
    input  logic [2:0][31:0] right_in,
    input  logic [2:0][31:0] up_in,
    input  logic [2:0][31:0] direction_in,
    output logic             gen_valid_out,
    output logic [2:0][31:0] gen_pos_out,
    output logic [2:0][31:0] gen_right_out,
    output logic [2:0][31:0] gen_up_out,
    output logic [2:0][31:0] gen_direction_out,
    input  logic             gen_valid_in,
    input  logic [3:0][31:0] gen_col_in,
    input  logic             frame_start_in,
    input  logic [1:0]       rd_col_in,
    output logic [3:0][31:0] rd_col_out,
    output logic             mat_valid_out,
    output logic             swap_out,
    output logic             err_out
);

    localparam int unsigned         WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]     WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      beat;
    logic [WD_W-1:0] wdog;
    logic            accept;
    logic            beat_wr;
    logic            abort;
    logic            commit;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    always_comb begin
        state_nxt     = state;
        cam_ready_out = 1'b0;
        gen_valid_out = 1'b0;
        accept        = 1'b0;
        abort         = 1'b0;
        commit        = 1'b0;
        case (state)
            ST_IDLE: begin
                cam_ready_out = 1'b1;
                if (cam_valid_in) begin
                    accept    = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                gen_valid_out = 1'b1;
                state_nxt     = ST_COLLECT;
            end
            ST_COLLECT: begin
                // A final beat landing on the timeout cycle still completes.
                if (gen_valid_in && (beat == 2'd3)) begin
                    state_nxt = ST_PENDING;
                end else if (wdog == WD_LAST) begin
                    abort     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (frame_start_in) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign beat_wr = (state == ST_COLLECT) && gen_valid_in;

    // NOTE: all state registers use non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            gen_pos_out       <= '0;
            gen_right_out     <= '0;
            gen_up_out        <= '0;
            gen_direction_out <= '0;
            beat              <= '0;
            wdog              <= '0;
            err_out           <= 1'b0;
            mat_valid_out     <= 1'b0;
            swap_out          <= 1'b0;
        end else begin
            if (accept) begin
                gen_pos_out       <= pos_in;
                gen_right_out     <= right_in;
                gen_up_out        <= up_in;
                gen_direction_out <= direction_in;
            end
            if (state == ST_ISSUE) begin
                beat <= '0;
                wdog <= '0;
            end else begin
                if (beat_wr) begin
                    beat <= beat + 2'd1;
                end
                if (state == ST_COLLECT) begin
                    wdog <= wdog + 1'b1;
                end
            end
            if (abort) begin
                err_out <= 1'b1;
            end
            if (commit) begin
                mat_valid_out <= 1'b1;
            end
            swap_out <= commit;
        end
    end

    view_matrix_bank u_bank (
        .clk    (clk_in),
        .rst_n  (rst_n_in),
        .wr_en  (beat_wr),
        .wr_idx (beat),
        .wr_col (gen_col_in),
        .clear  (abort),
        .swap   (commit),
        .rd_idx (rd_col_in),
        .rd_col (rd_col_out)
    );

endmodule
